// File: rtl/fpu_sp_minmax_seq.sv
// fpu_sp_minmax_seq: streaming binary32 min/max reducer, one compare per element.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_last element
// stream; out_valid/out_ready handshake with out_max, out_min, out_max_idx,
// out_min_idx, out_count (saturating) and out_nan.
// Optional: define FPU_CMP_NAN_EN to keep NaNs out of the extrema and flag them.
module fpu_sp_minmax_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_max,
  output logic [31:0]      out_min,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_min_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CMP,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_t state;
  state_t stateNext;

  logic rdyQ;
  logic vldQ;

  logic [31:0]      maxQ;
  logic [31:0]      minQ;
  logic [CNT_W-1:0] maxIdxQ;
  logic [CNT_W-1:0] minIdxQ;
  logic [CNT_W-1:0] cntQ;

  logic [31:0]      opQ;
  logic [CNT_W-1:0] opIdxQ;
  logic             opLastQ;

  logic inFire;
  logic outFire;
  logic opGtMax;
  logic opLtMin;

  // Team comparator ordering: sign first, then magnitude bits,
  // reversed for negatives; identical words are never "greater".
  function automatic logic fpGt(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic r;
    if (a[31] != b[31]) begin
      r = ~a[31];
    end else if (!a[31]) begin
      r = (a > b);
    end else begin
      r = (a < b);
    end
    return r;
  endfunction

  // Handshake qualifiers; ready/valid are registered so these
  // never feed back combinationally into any output.
  assign inFire  = in_valid & rdyQ;
  assign outFire = vldQ & out_ready;

  // Strict compares so ties keep the earlier index.
  assign opGtMax = fpGt(opQ, maxQ);
  assign opLtMin = fpGt(minQ, opQ);

`ifdef FPU_CMP_NAN_EN
  localparam logic [31:0] QNaN = 32'h7FC0_0000;

  logic nanQ;
  logic haveQ;
  logic inIsNan;
  logic opIsNan;

  function automatic logic isNan(input logic [31:0] x);
    return (&x[30:23]) & (|x[22:0]);
  endfunction

  assign inIsNan = isNan(in_data);
  assign opIsNan = isNan(opQ);
`endif

  // Next-state decode.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (inFire) begin
          stateNext = in_last ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (inFire) begin
          stateNext = CMP;
        end
      end
      CMP: begin
        stateNext = opLastQ ? DONE : FETCH;
      end
      DONE: begin
        if (outFire) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State plus registered handshake outputs, decoded one cycle
  // early from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdyQ  <= 1'b0;
      vldQ  <= 1'b0;
    end else begin
      state <= stateNext;
      rdyQ  <= (stateNext == IDLE) |
               (stateNext == FETCH);
      vldQ  <= (stateNext == DONE);
    end
  end

  // Result and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      maxQ    <= '0;
      minQ    <= '0;
      maxIdxQ <= '0;
      minIdxQ <= '0;
      cntQ    <= '0;
      opQ     <= '0;
      opIdxQ  <= '0;
      opLastQ <= 1'b0;
`ifdef FPU_CMP_NAN_EN
      nanQ    <= 1'b0;
      haveQ   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (inFire) begin
            cntQ    <= CntOne;
            maxIdxQ <= '0;
            minIdxQ <= '0;
`ifdef FPU_CMP_NAN_EN
            // A leading NaN parks the extrema at the canonical
            // quiet NaN until a real number shows up.
            nanQ  <= inIsNan;
            haveQ <= ~inIsNan;
            maxQ  <= inIsNan ? QNaN : in_data;
            minQ  <= inIsNan ? QNaN : in_data;
`else
            maxQ  <= in_data;
            minQ  <= in_data;
`endif
          end
        end
        FETCH: begin
          if (inFire) begin
            opQ     <= in_data;
            opLastQ <= in_last;
            // Once the count pins at all-ones, later elements
            // share the all-ones index.
            opIdxQ  <= cntQ;
            if (cntQ != CntMax) begin
              cntQ <= cntQ + CntOne;
            end
          end
        end
        CMP: begin
`ifdef FPU_CMP_NAN_EN
          if (opIsNan) begin
            nanQ <= 1'b1;
          end else if (!haveQ) begin
            maxQ    <= opQ;
            minQ    <= opQ;
            maxIdxQ <= opIdxQ;
            minIdxQ <= opIdxQ;
            haveQ   <= 1'b1;
          end else begin
            if (opGtMax) begin
              maxQ    <= opQ;
              maxIdxQ <= opIdxQ;
            end
            if (opLtMin) begin
              minQ    <= opQ;
              minIdxQ <= opIdxQ;
            end
          end
`else
          if (opGtMax) begin
            maxQ    <= opQ;
            maxIdxQ <= opIdxQ;
          end
          if (opLtMin) begin
            minQ    <= opQ;
            minIdxQ <= opIdxQ;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready    = rdyQ;
  assign out_valid   = vldQ;
  assign out_max     = maxQ;
  assign out_min     = minQ;
  assign out_max_idx = maxIdxQ;
  assign out_min_idx = minIdxQ;
  assign out_count   = cntQ;

`ifdef FPU_CMP_NAN_EN
  assign out_nan = nanQ;
`else
  assign out_nan = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_sp_minmax_seq.sv
// tb_fpu_sp_minmax_seq: scoreboard bench for fpu_sp_minmax_seq.
// A second narrow-count instance shares the stream to reach saturation.
module tb_fpu_sp_minmax_seq;

`ifdef FPU_CMP_NAN_EN
  localparam bit NanEn = 1'b1;
`else
  localparam bit NanEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] mx;
    logic [31:0] mn;
    logic [15:0] mxI;
    logic [15:0] mnI;
    logic [15:0] cnt;
    logic        nan;
    logic [31:0] rise;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold2 = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_max;
  logic [31:0] out_min;
  logic [15:0] out_max_idx;
  logic [15:0] out_min_idx;
  logic [15:0] out_count;
  logic        out_nan;

  logic        rst2;
  logic        rdy2;
  logic        vld2;
  logic [31:0] max2;
  logic [31:0] min2;
  logic [2:0]  maxI2;
  logic [2:0]  minI2;
  logic [2:0]  cnt2;
  logic        nan2;

  int nChk = 0;
  int nPass = 0;
  int cyc = 0;
  int maxSend = 1000;
  int stall1 = 0;
  logic [31:0] frm[$];
  res_t sb[$];
  res_t got[$];
  logic ovPrev = 1'b0;
  int riseCyc = 0;

  assign rst2 = rst | hold2;

  fpu_sp_minmax_seq #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_min(out_min),
    .out_max_idx(out_max_idx),
    .out_min_idx(out_min_idx),
    .out_count(out_count), .out_nan(out_nan)
  );

  fpu_sp_minmax_seq #(.CNT_W(3)) dutSat (
    .clk(clk), .rst(rst2),
    .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy2),
    .out_valid(vld2), .out_ready(out_ready),
    .out_max(max2), .out_min(min2),
    .out_max_idx(maxI2), .out_min_idx(minI2),
    .out_count(cnt2), .out_nan(nan2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Result monitor: samples just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      ovPrev = 1'b0;
    end else begin
      if (out_valid && !ovPrev) riseCyc = cyc;
      ovPrev = out_valid;
      if (out_valid && out_ready)
        got.push_back({out_max, out_min,
          out_max_idx, out_min_idx, out_count,
          out_nan, 32'(riseCyc)});
    end
  end

  function automatic res_t mk(
    input logic [31:0] mx, input logic [31:0] mn,
    input logic [15:0] mxI, input logic [15:0] mnI,
    input logic [15:0] cnt, input logic nan,
    input int rise
  );
    return {mx, mn, mxI, mnI, cnt, nan, 32'(rise)};
  endfunction

  task automatic send_frame(output int t0);
    int g;
    t0 = cyc;
    for (int k = 0; k < frm.size() && k < maxSend; k++) begin
      if (k == 1) repeat (stall1) @(negedge clk);
      in_valid = 1'b1;
      in_data  = frm[k];
      in_last  = (k == frm.size() - 1);
      g = 0;
      while (!in_ready && g < 40) begin
        @(negedge clk);
        g++;
      end
      if (!in_ready) begin
        nChk++;
        $display("FAIL accept: elem %0d ready %b want 1",
                 k, in_ready);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      if (k == 0) t0 = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_got();
    int g = 0;
    while (got.size() == 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    nChk++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL rst_hs: rdy %b vld %b want 0 0",
               in_ready, out_valid);
    else nPass++;
    nChk++;
    if ({out_max, out_min, out_max_idx, out_min_idx,
         out_count, out_nan} !== '0)
      $display("FAIL rst_data: max %h min %h cnt %h",
               out_max, out_min, out_count);
    else nPass++;
    rst = 1'b0;
    @(negedge clk);
    nChk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL rst_rel: rdy %b vld %b want 1 0",
               in_ready, out_valid);
    else nPass++;
  endtask

  task automatic test_single();
    int t0;
    res_t r;
    res_t e;
    frm = '{32'h3F800000};
    send_frame(t0);
    sb.push_back(mk(32'h3F800000, 32'h3F800000,
                    0, 0, 1, 1'b0, t0 + 1));
    wait_got();
    e = sb.pop_front();
    nChk++;
    if (got.size() == 0) begin
      $display("FAIL single: no result, want %p", e);
    end else begin
      r = got.pop_front();
      if (r !== e) $display("FAIL single: got %p want %p", r, e);
      else nPass++;
    end
  endtask

  task automatic test_frame4();
    int t0;
    res_t r;
    res_t e;
    frm = '{32'h3F800000, 32'hC0000000,
            32'h40600000, 32'hBF000000};
    send_frame(t0);
    sb.push_back(mk(32'h40600000, 32'hC0000000,
                    2, 1, 4, 1'b0, t0 + 7));
    wait_got();
    e = sb.pop_front();
    nChk++;
    if (got.size() == 0) begin
      $display("FAIL frame4: no result, want %p", e);
    end else begin
      r = got.pop_front();
      if (r !== e) $display("FAIL frame4: got %p want %p", r, e);
      else nPass++;
    end
  endtask

  task automatic test_zero_tie();
    int t0;
    res_t r;
    res_t e;
    frm = '{32'h80000000, 32'h00000000, 32'h00000000};
    send_frame(t0);
    sb.push_back(mk(32'h00000000, 32'h80000000,
                    1, 0, 3, 1'b0, t0 + 5));
    wait_got();
    e = sb.pop_front();
    nChk++;
    if (got.size() == 0) begin
      $display("FAIL zero_tie: no result, want %p", e);
    end else begin
      r = got.pop_front();
      if (r !== e) $display("FAIL zero_tie: got %p want %p", r, e);
      else nPass++;
    end
  endtask

  task automatic test_backpressure();
    int t0;
    int t1;
    int tRel;
    int g = 0;
    res_t r;
    res_t e;
    out_ready = 1'b0;
    frm = '{32'h3F800000, 32'h40000000};
    send_frame(t0);
    sb.push_back(mk(32'h40000000, 32'h3F800000,
                    1, 0, 2, 1'b0, t0 + 3));
    while (!out_valid && g < 40) begin
      @(negedge clk);
      g++;
    end
    for (int i = 0; i < 5; i++) begin
      nChk++;
      if ({out_valid, in_ready, out_max, out_min,
           out_max_idx, out_min_idx, out_count} !==
          {1'b1, 1'b0, 32'h40000000, 32'h3F800000,
           16'd1, 16'd0, 16'd2})
        $display("FAIL hold%0d: vld %b rdy %b max %h min %h cnt %0d want 1 0 40000000 3f800000 2",
                 i, out_valid, in_ready, out_max,
                 out_min, out_count);
      else nPass++;
      if (i < 4) @(negedge clk);
    end
    out_ready = 1'b1;
    tRel = cyc;
    @(negedge clk);
    nChk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL release: rdy %b vld %b want 1 0",
               in_ready, out_valid);
    else nPass++;
    frm = '{32'hC0000000};
    send_frame(t1);
    sb.push_back(mk(32'hC0000000, 32'hC0000000,
                    0, 0, 1, 1'b0, t1 + 1));
    nChk++;
    if (t1 !== tRel + 1)
      $display("FAIL next_accept: cycle %0d want %0d",
               t1, tRel + 1);
    else nPass++;
    for (int i = 0; i < 2; i++) begin
      wait_got();
      e = sb.pop_front();
      nChk++;
      if (got.size() == 0) begin
        $display("FAIL bp_res%0d: no result, want %p", i, e);
      end else begin
        r = got.pop_front();
        if (r !== e)
          $display("FAIL bp_res%0d: got %p want %p", i, r, e);
        else nPass++;
      end
    end
  endtask

  task automatic test_mid_reset();
    int t0;
    res_t r;
    res_t e;
    frm = '{32'h40400000, 32'h40800000,
            32'h3F800000, 32'h41000000};
    maxSend = 2;
    send_frame(t0);
    maxSend = 1000;
    rst = 1'b1;
    @(negedge clk);
    nChk++;
    if ({in_ready, out_valid, out_max, out_min,
         out_max_idx, out_min_idx, out_count,
         out_nan} !== '0)
      $display("FAIL mid_rst: rdy %b vld %b max %h cnt %0d want all 0",
               in_ready, out_valid, out_max, out_count);
    else nPass++;
    rst = 1'b0;
    @(negedge clk);
    nChk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        got.size() != 0)
      $display("FAIL mid_rel: rdy %b vld %b results %0d want 1 0 0",
               in_ready, out_valid, got.size());
    else nPass++;
    frm = '{32'h40000000, 32'h3F000000};
    send_frame(t0);
    sb.push_back(mk(32'h40000000, 32'h3F000000,
                    0, 1, 2, 1'b0, t0 + 3));
    wait_got();
    e = sb.pop_front();
    nChk++;
    if (got.size() == 0) begin
      $display("FAIL mid_new: no result, want %p", e);
    end else begin
      r = got.pop_front();
      if (r !== e) $display("FAIL mid_new: got %p want %p", r, e);
      else nPass++;
    end
  endtask

  task automatic test_nan();
    int t0;
    res_t r;
    res_t e;
    frm = '{32'h7FC00000, 32'h40000000, 32'hFF800001};
    send_frame(t0);
    if (NanEn)
      sb.push_back(mk(32'h40000000, 32'h40000000,
                      1, 1, 3, 1'b1, t0 + 5));
    else
      sb.push_back(mk(32'h7FC00000, 32'hFF800001,
                      0, 2, 3, 1'b0, t0 + 5));
    frm = '{32'hFFC00000, 32'h7F800001};
    send_frame(t0);
    if (NanEn)
      sb.push_back(mk(32'h7FC00000, 32'h7FC00000,
                      0, 0, 2, 1'b1, t0 + 3));
    else
      sb.push_back(mk(32'h7F800001, 32'hFFC00000,
                      1, 0, 2, 1'b0, t0 + 3));
    frm = '{32'h3F800000};
    send_frame(t0);
    sb.push_back(mk(32'h3F800000, 32'h3F800000,
                    0, 0, 1, 1'b0, t0 + 1));
    for (int i = 0; i < 3; i++) begin
      wait_got();
      e = sb.pop_front();
      nChk++;
      if (got.size() == 0) begin
        $display("FAIL nan%0d: no result, want %p", i, e);
      end else begin
        r = got.pop_front();
        if (r !== e)
          $display("FAIL nan%0d: got %p want %p", i, r, e);
        else nPass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    res_t r;
    res_t e;
    frm = '{32'hBF800000, 32'hC0400000};
    stall1 = 3;
    send_frame(t0);
    stall1 = 0;
    sb.push_back(mk(32'hBF800000, 32'hC0400000,
                    0, 1, 2, 1'b0, t0 + 6));
    frm = '{32'h00000000};
    send_frame(t1);
    sb.push_back(mk(32'h00000000, 32'h00000000,
                    0, 0, 1, 1'b0, t1 + 1));
    nChk++;
    if (t1 !== t0 + 7)
      $display("FAIL b2b_accept: cycle %0d want %0d",
               t1 - t0, 7);
    else nPass++;
    for (int i = 0; i < 2; i++) begin
      wait_got();
      e = sb.pop_front();
      nChk++;
      if (got.size() == 0) begin
        $display("FAIL b2b%0d: no result, want %p", i, e);
      end else begin
        r = got.pop_front();
        if (r !== e)
          $display("FAIL b2b%0d: got %p want %p", i, r, e);
        else nPass++;
      end
    end
  endtask

  task automatic test_saturation();
    int t0;
    int g = 0;
    res_t r;
    res_t e;
    hold2 = 1'b0;
    repeat (2) @(negedge clk);
    frm = '{32'h3F800000, 32'h40000000, 32'h3F000000,
            32'hBF800000, 32'h3F800000, 32'h3F800000,
            32'h3F800000, 32'h3F800000, 32'h3F800000,
            32'h41000000};
    send_frame(t0);
    sb.push_back(mk(32'h41000000, 32'hBF800000,
                    9, 3, 10, 1'b0, t0 + 19));
    while (!vld2 && g < 40) begin
      @(negedge clk);
      g++;
    end
    nChk++;
    if ({vld2, max2, min2, maxI2, minI2, cnt2, nan2} !==
        {1'b1, 32'h41000000, 32'hBF800000,
         3'd7, 3'd3, 3'd7, 1'b0})
      $display("FAIL sat: vld %b max %h min %h idx %0d/%0d cnt %0d want 1 41000000 bf800000 7/3 7",
               vld2, max2, min2, maxI2, minI2, cnt2);
    else nPass++;
    wait_got();
    e = sb.pop_front();
    nChk++;
    if (got.size() == 0) begin
      $display("FAIL sat_wide: no result, want %p", e);
    end else begin
      r = got.pop_front();
      if (r !== e) $display("FAIL sat_wide: got %p want %p", r, e);
      else nPass++;
    end
    hold2 = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: cycle %0d want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_frame4();
    test_zero_tie();
    test_backpressure();
    test_mid_reset();
    test_nan();
    test_back_to_back();
    test_saturation();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/fpu_sp_minmax_seq.md
# fpu_sp_minmax_seq

Streaming single-precision min/max reducer: the initiator-side counterpart of the FPU comparator. It accepts a frame of IEEE-754 binary32 words over a valid/ready handshake and issues one registered compare per element against the running extrema. At end of frame it presents the maximum, the minimum, their element indices and the element count. It sits between an operand stream (DMA/accelerator FIFO) and a result consumer.

## Interface
- CNT_W, 16, width of count and index fields
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input element valid
- in_data  in  32  binary32 element
- in_last  in  1  element is the last of the frame
- in_ready  out  1  block accepts an element this cycle
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer accepts the result
- out_max, out_min  out  32  extremum values (raw bits)
- out_max_idx, out_min_idx  out  CNT_W  zero-based element index of each extremum
- out_count  out  CNT_W  elements in frame (saturating)
- out_nan  out  1  frame contained a NaN (tied 0 when the NaN feature is compiled out)

## Operation
- Ordering, identical to the team comparator:
  - Signs differ: the positive word is greater. +0 > -0.
  - Both positive: unsigned compare of raw bits.
  - Both negative: reversed unsigned compare.
  - Equal only when the bits are identical.
- FSM states: IDLE, FETCH, CMP, DONE. in_ready = 1 in IDLE/FETCH only. out_valid = 1 in DONE only.
- IDLE, on handshake: max = min = in_data; both idx = 0; count = 1. Next state is DONE if in_last, else FETCH.
- FETCH, on handshake:
  - Latch operand and last flag.
  - Operand idx = count; count++.
  - Next state: CMP.
- CMP:
  - Operand > max: replace max and max_idx.
  - Operand < min: replace min and min_idx.
  - Ties keep the earlier index.
  - Next state is DONE if the latched last flag is set, else FETCH.
- DONE: outputs held stable. On out_ready, go to IDLE. The result registers keep their values until the next frame's first element loads them.
- No handshake means no state change. in_last is sampled only on handshake.
- Saturation:
  - out_count saturates at all-ones.
  - Elements accepted after saturation take idx all-ones.
  - Extrema tracking continues after saturation.
- Reset values: in_ready 0 during reset, 1 on the cycle after reset deasserts (IDLE). All other outputs are 0. State is IDLE.
- Reset mid-frame: the frame is abandoned with no result emitted, and the next frame starts clean.

## Timing
- Cycle 0 is the first handshake. Element k≥1 is accepted no earlier than cycle 2k-1, so throughput is one element per 2 cycles.
- out_valid rises at cycle 2N-1 for an N-element frame with no input stalls (N=1 gives cycle 1).
- Input stalls in FETCH add cycles one-for-one.
- Result-to-next-frame: the out handshake in cycle t returns the block to IDLE, and the next first element can be accepted in cycle t+1.
- All outputs are registered or decoded from registered state. No combinational path runs from in_valid or out_ready to any output.

## Configuration
- FPU_CMP_NAN_EN defined:
  - Elements with exponent 0xFF and mantissa ≠ 0 are counted and set out_nan, but are excluded from the extrema.
  - The first non-NaN element loads max/min and its index.
  - An all-NaN frame reports out_max = out_min = 0x7FC00000 with both idx 0.
  - out_nan clears on the next frame's first handshake.
- FPU_CMP_NAN_EN undefined: NaNs are ordered by raw bits like any other word, and out_nan is constant 0.

## Test plan
- Single element 0x3F800000 with last → out_valid at cycle 1; max = min = 0x3F800000; idx 0/0; count 1.
- Frame [0x3F800000, 0xC0000000, 0x40600000, 0xBF000000] back-to-back → out_valid at cycle 7; max 0x40600000 idx 2; min 0xC0000000 idx 1; count 4.
- Frame [0x80000000, 0x00000000, 0x00000000] → max 0x00000000 idx 1 (tie keeps earlier); min 0x80000000 idx 0; count 3.
- Hold out_ready low 5 cycles in DONE → out_valid and all result fields stable, in_ready 0. Release → IDLE, and the next frame is accepted the following cycle.
- Assert rst after 2 of 4 elements → next cycle all outputs 0, no out_valid. After release, a new 2-element frame [0x40000000, 0x3F000000] gives max 0x40000000 idx 0, min 0x3F000000 idx 1, count 2.
- Frame [0x7FC00000, 0x40000000, 0xFF800001]:
  - With FPU_CMP_NAN_EN → max = min = 0x40000000, idx 1/1, count 3, out_nan 1.
  - Without → max 0x7FC00000 idx 0, min 0xFF800001 idx 2, out_nan 0.
